// File: rtl/latch_bank_arbiter_if.sv
// Write-request / latch-bank bus between requesters (master) and latch_bank_arbiter (slave).
// Lock signals exist only when LATCH_ARB_LOCK_EN is defined.
interface latch_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               hold;
  logic [NREQ-1:0]    ack;
  logic [2**AW-1:0]   lat_en;
  logic [DW-1:0]      lat_d;
  logic               busy;
`ifdef LATCH_ARB_LOCK_EN
  logic [2**AW-1:0]   lock_set;
  logic               wr_err;

  modport master (output req, req_addr, req_data, hold, lock_set,
                  input  ack, lat_en, lat_d, busy, wr_err);
  modport slave  (input  req, req_addr, req_data, hold, lock_set,
                  output ack, lat_en, lat_d, busy, wr_err);
`else
  modport master (output req, req_addr, req_data, hold,
                  input  ack, lat_en, lat_d, busy);
  modport slave  (input  req, req_addr, req_data, hold,
                  output ack, lat_en, lat_d, busy);
`endif
endinterface

// File: rtl/latch_bank_arbiter.sv
// Round-robin write scheduler driving a bank of enable-load latch words, one strobe per cycle.
// Optional sticky per-word write locks are enabled by defining LATCH_ARB_LOCK_EN.
module latch_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 16
) (
  input  logic          i_sys_clk,
  input  logic          i_reset,
  latch_bank_arbiter_if.slave bus
);
  localparam int NW = 2**AW;
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] r_ack;
  logic [NW-1:0]   r_lat_en;
  logic [DW-1:0]   r_lat_d;
  logic [PW-1:0]   r_ptr;

  logic [NREQ-1:0] w_elig;
  logic            w_grant;
  logic [PW-1:0]   w_win;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic            w_blocked;

  // A request acked this cycle is masked so a requester dropping req late is not written twice.
  assign w_elig = bus.req & ~r_ack;

  always_comb begin
    w_grant = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_grant && w_elig[(int'(r_ptr) + k) % NREQ]) begin
        w_grant = 1'b1;
        w_win   = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
    if (bus.hold) w_grant = 1'b0;
  end

  assign w_addr = bus.req_addr[w_win*AW +: AW];
  assign w_data = bus.req_data[w_win*DW +: DW];

`ifdef LATCH_ARB_LOCK_EN
  logic [NW-1:0] r_lock;
  logic [NW-1:0] w_lock_next;
  logic          r_wr_err;

  // Same-cycle lock_set already blocks the write being granted.
  assign w_lock_next = r_lock | bus.lock_set;
  assign w_blocked   = w_lock_next[w_addr];

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_lock   <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_lock   <= w_lock_next;
      r_wr_err <= w_grant & w_blocked;
    end
  end

  assign bus.wr_err = r_wr_err;
`else
  assign w_blocked = 1'b0;
`endif

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_ack    <= '0;
      r_lat_en <= '0;
      r_lat_d  <= '0;
      r_ptr    <= '0;
    end else begin
      r_ack    <= '0;
      r_lat_en <= '0;
      if (w_grant) begin
        r_ack <= NREQ'(1) << w_win;
        if (!w_blocked) begin
          r_lat_en <= NW'(1) << w_addr;
          r_lat_d  <= w_data;
        end
        r_ptr <= (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;
      end
    end
  end

  assign bus.ack    = r_ack;
  assign bus.lat_en = r_lat_en;
  assign bus.lat_d  = r_lat_d;
  assign bus.busy   = |w_elig;
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Scoreboard bench for latch_bank_arbiter; lock tests run when LATCH_ARB_LOCK_EN is defined.
module tb_latch_bank_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 16;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [7:0]      en;
    logic [DW-1:0]   d;
    logic            err;
  } exp_t;

  logic clk;
  logic reset;
  int   vecCount;
  int   missCount;
  exp_t expQ[$];

  latch_bank_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  latch_bank_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .i_sys_clk(clk),
    .i_reset  (reset),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.req_addr[idx*AW +: AW] = addr;
    bus.req_data[idx*DW +: DW] = data;
  endtask

  task automatic pushExp(input logic [NREQ-1:0] ack, input logic [7:0] en,
                         input logic [DW-1:0] d, input logic err);
    exp_t e;
    e.ack = ack; e.en = en; e.d = d; e.err = err;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    bus.req = '0;
    bus.hold = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every ack pulse is matched against the next scoreboard entry.
  always @(negedge clk) begin
    logic err;
`ifdef LATCH_ARB_LOCK_EN
    err = bus.wr_err;
`else
    err = 1'b0;
`endif
    if (bus.ack != '0) begin
      vecCount++;
      if (expQ.size() == 0) begin
        missCount++;
        $display("[TB] FAIL unexpected_ack: got ack=%b lat_en=%b, expected none", bus.ack, bus.lat_en);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (bus.ack !== e.ack || bus.lat_en !== e.en || bus.lat_d !== e.d || err !== e.err) begin
          missCount++;
          $display("[TB] FAIL strobe: got ack=%b en=%b d=%h err=%b, expected ack=%b en=%b d=%h err=%b",
                   bus.ack, bus.lat_en, bus.lat_d, err, e.ack, e.en, e.d, e.err);
        end
      end
    end else if (bus.lat_en != '0 || err) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL stray_strobe: got lat_en=%b err=%b with no ack, expected 0", bus.lat_en, err);
    end
  end

  initial begin
    vecCount  = 0;
    missCount = 0;
    reset     = 1'b1;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.hold     = 1'b0;
`ifdef LATCH_ARB_LOCK_EN
    bus.lock_set = '0;
`endif
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_ack",    32'(bus.ack),    32'h0);
    checkOutput("rst_lat_en", 32'(bus.lat_en), 32'h0);
    checkOutput("rst_lat_d",  32'(bus.lat_d),  32'h0);
    checkOutput("rst_busy",   32'(bus.busy),   32'h0);

    // Single write, one-cycle strobe
    applyStimulus(0, 3'd5, 16'hA5A5);
    pushExp(4'b0001, 8'b0010_0000, 16'hA5A5, 1'b0);
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    checkOutput("t1_lat_en_off", 32'(bus.lat_en), 32'h0);
    checkOutput("t1_ack_off",    32'(bus.ack),    32'h0);
    checkOutput("t1_lat_d_hold", 32'(bus.lat_d),  32'hA5A5);

    // All four requesting continuously: round-robin 0,1,2,3,0,1,2,3
    doReset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 3'(i), 16'hB000 + 16'(i));
    for (int k = 0; k < 8; k++)
      pushExp(4'(1 << (k % 4)), 8'(1 << (k % 4)), 16'hB000 + 16'(k % 4), 1'b0);
    bus.req = 4'b1111;
    tick(); tick(); tick();
    checkOutput("t2_busy", 32'(bus.busy), 32'h1);
    tick(); tick(); tick(); tick(); tick();
    bus.req = 4'b0000;
    tick();
    checkOutput("t2_busy_idle", 32'(bus.busy), 32'h0);

    // Hold suppresses grants for three cycles
    doReset();
    applyStimulus(1, 3'd1, 16'hC001);
    applyStimulus(2, 3'd6, 16'hC002);
    bus.hold = 1'b1;
    bus.req  = 4'b0110;
    tick(); tick(); tick();
    checkOutput("t3_hold_busy", 32'(bus.busy), 32'h1);
    checkOutput("t3_hold_ack",  32'(bus.ack),  32'h0);
    pushExp(4'b0010, 8'b0000_0010, 16'hC001, 1'b0);
    pushExp(4'b0100, 8'b0100_0000, 16'hC002, 1'b0);
    bus.hold = 1'b0;
    tick();
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    tick();

    // Same address from two requesters: serialised, last strobe wins
    doReset();
    applyStimulus(0, 3'd2, 16'h1111);
    applyStimulus(2, 3'd2, 16'h2222);
    pushExp(4'b0001, 8'b0000_0100, 16'h1111, 1'b0);
    pushExp(4'b0100, 8'b0000_0100, 16'h2222, 1'b0);
    bus.req = 4'b0101;
    tick();
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    tick();
    checkOutput("t4_last_wins", 32'(bus.lat_d), 32'h2222);

    // Reset right after a grant registers; pointer must return to 0
    doReset();
    applyStimulus(2, 3'd4, 16'h5555);
    applyStimulus(3, 3'd7, 16'h7777);
    pushExp(4'b0100, 8'b0001_0000, 16'h5555, 1'b0);
    bus.req = 4'b0100;
    tick();
    reset = 1'b1;
    tick();
    checkOutput("t5_rst_ack",    32'(bus.ack),    32'h0);
    checkOutput("t5_rst_lat_en", 32'(bus.lat_en), 32'h0);
    checkOutput("t5_rst_lat_d",  32'(bus.lat_d),  32'h0);
    checkOutput("t5_rst_busy",   32'(bus.busy),   32'h1);
    reset = 1'b0;
    pushExp(4'b0100, 8'b0001_0000, 16'h5555, 1'b0);
    pushExp(4'b1000, 8'b1000_0000, 16'h7777, 1'b0);
    bus.req = 4'b1100;
    tick();
    bus.req = 4'b1000;
    tick();
    bus.req = 4'b0000;
    tick();

`ifdef LATCH_ARB_LOCK_EN
    // Locked word: ack and wr_err pulse, no strobe, lat_d unchanged
    doReset();
    bus.lock_set = 8'h08;
    tick();
    bus.lock_set = 8'h00;
    applyStimulus(1, 3'd3, 16'h7777);
    pushExp(4'b0010, 8'h00, 16'h0000, 1'b1);
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    tick();
    applyStimulus(1, 3'd4, 16'h8888);
    pushExp(4'b0010, 8'b0001_0000, 16'h8888, 1'b0);
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    tick();
    // Lock set in the same cycle as the grant blocks that grant
    applyStimulus(0, 3'd5, 16'h9999);
    pushExp(4'b0001, 8'h00, 16'h8888, 1'b1);
    bus.lock_set = 8'h20;
    bus.req = 4'b0001;
    tick();
    bus.lock_set = 8'h00;
    bus.req = 4'b0000;
    tick();
`endif

    tick();
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
